// File: rtl/io_input_ctrl_pkg.sv
// Shared constants for io_input_ctrl: register-select codes (addr[7:2]) and the scan FSM state type.
package io_pkg;

    localparam logic [5:0] ADDR_PORT0   = 6'b110000;
    localparam logic [5:0] ADDR_PORT1   = 6'b110001;
    localparam logic [5:0] ADDR_PORT2   = 6'b110010;
    localparam logic [5:0] ADDR_PORT3   = 6'b110011;
    localparam logic [5:0] ADDR_STATUS  = 6'b110100;
    localparam logic [5:0] ADDR_IRQMASK = 6'b110101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } scan_state_e;

    // The four port selects share the upper code bits; the low two bits pick the port.
    function automatic logic is_port_sel(input logic [5:0] sel);
        return sel[5:2] == ADDR_PORT0[5:2];
    endfunction

endpackage

// File: rtl/io_input_ctrl_if.sv
// CPU read bus of io_input_ctrl: the CPU drives the master side, the controller the slave side.
interface io_input_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       addr;
    logic              rd_en;
    logic [DATA_W-1:0] in_data;
    logic              rd_valid;

    modport master (output addr, output rd_en, input in_data, input rd_valid);
    modport slave  (input addr, input rd_en, output in_data, output rd_valid);
endinterface

// File: rtl/io_scan_fsm.sv
// Scan sequencer: free-running sample-tick divider plus IDLE/SCAN/COMMIT FSM walking the port index.
module io_scan_fsm
    import io_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 4
) (
    input  logic        io_clk,
    input  logic        reset,
    output scan_state_e state_o,
    output logic [1:0]  idx_o,
    output logic        scan_busy_o
);

    localparam logic [7:0] TICK_LAST = 8'(SAMPLE_DIV - 1);

    logic [7:0]  cnt_q;
    logic        tick;
    scan_state_e state_q;
    logic [1:0]  idx_q;
    logic        busy_q;

    assign tick = (cnt_q == TICK_LAST);

    always_ff @(posedge io_clk) begin
        if (reset || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Ticks seen outside IDLE are simply ignored, so a long scan drops them.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q <= ST_SCAN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q <= ST_COMMIT;
                        busy_q  <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state_o     = state_q;
    assign idx_o       = idx_q;
    assign scan_busy_o = busy_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Polled input-port controller: periodic scan into shadow, commit to held data with change flags, CPU read mux.
// Optional interrupt with CPU-writable mask is built when IO_INPUT_IRQ_EN is defined.
module io_input_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SAMPLE_DIV = 4
) (
    input  logic              io_clk,
    input  logic              reset,
    io_input_ctrl_if.slave    bus,
    input  logic [DATA_W-1:0] in_port0,
    input  logic [DATA_W-1:0] in_port1,
    input  logic [DATA_W-1:0] in_port2,
    input  logic [DATA_W-1:0] in_port3,
    output logic              scan_busy,
    output logic              irq
);

    scan_state_e       state;
    logic [1:0]        idx;
    logic [DATA_W-1:0] port_w   [4];
    logic [DATA_W-1:0] shadow_q [4];
    logic [DATA_W-1:0] shadow_d [4];
    logic [DATA_W-1:0] held_q   [4];
    logic [DATA_W-1:0] held_d   [4];
    logic [3:0]        flag_q, flag_d, set_w, clr_w;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [5:0]        sel;
    logic              unused_addr;

    io_scan_fsm #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_scan (
        .io_clk     (io_clk),
        .reset      (reset),
        .state_o    (state),
        .idx_o      (idx),
        .scan_busy_o(scan_busy)
    );

    assign port_w[0]   = in_port0;
    assign port_w[1]   = in_port1;
    assign port_w[2]   = in_port2;
    assign port_w[3]   = in_port3;
    assign sel         = bus.addr[7:2];
    assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

    // A commit-time set beats a same-cycle read clear; the read still returns the old held value.
    always_comb begin
        shadow_d = shadow_q;
        held_d   = held_q;
        set_w    = '0;
        clr_w    = '0;
        data_d   = data_q;
        valid_d  = bus.rd_en;
        if (state == ST_SCAN) begin
            shadow_d[idx] = port_w[idx];
        end
        if (state == ST_COMMIT) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (shadow_q[k[1:0]] != held_q[k[1:0]]) begin
                    held_d[k[1:0]] = shadow_q[k[1:0]];
                    set_w[k[1:0]]  = 1'b1;
                end
            end
        end
        if (bus.rd_en) begin
            data_d = '0;
            if (is_port_sel(sel)) begin
                data_d          = held_q[sel[1:0]];
                clr_w[sel[1:0]] = 1'b1;
            end else if (sel == ADDR_STATUS) begin
                data_d[4:0] = {scan_busy, flag_q};
            end
        end
        flag_d = set_w | (flag_q & ~clr_w);
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            shadow_q <= '{default: '0};
            held_q   <= '{default: '0};
            flag_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            held_q   <= held_d;
            flag_q   <= flag_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.in_data  = data_q;
    assign bus.rd_valid = valid_q;

`ifdef IO_INPUT_IRQ_EN
    logic [3:0] mask_q, mask_d;
    logic       irq_q;

    // The mask write rides on a read strobe; the read itself returns zero via the mux default.
    always_comb begin
        mask_d = mask_q;
        if (bus.rd_en && (sel == ADDR_IRQMASK)) begin
            mask_d = bus.addr[11:8];
        end
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            mask_q <= 4'hF;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |(flag_d & mask_d);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl: directed scenarios plus random traffic against a schedule-level reference model.
module tb_io_input_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned SD = 4;

    typedef struct packed {
        logic          valid;
        logic          busy;
        logic          irq;
        logic [DW-1:0] data;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p [4];
    logic          scan_busy;
    logic          irq;

    io_input_ctrl_if #(.DATA_W(DW)) bus ();

    io_input_ctrl #(
        .DATA_W    (DW),
        .SAMPLE_DIV(SD)
    ) dut (
        .io_clk   (clk),
        .reset    (rst),
        .bus      (bus),
        .in_port0 (p[0]),
        .in_port1 (p[1]),
        .in_port2 (p[2]),
        .in_port3 (p[3]),
        .scan_busy(scan_busy),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    cyc_t          stq [$];
    logic [DW-1:0] rdq [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference state: m_n counts non-reset edges, m_s is the edge a scan started on (-1 = none).
    logic [DW-1:0] m_held   [4];
    logic [DW-1:0] m_shadow [4];
    logic [DW-1:0] m_data;
    logic [3:0]    m_flag;
    logic [3:0]    m_mask;
    int            m_n;
    int            m_s;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_edge(input logic r, input logic rd, input logic [31:0] a,
                                       input logic use_fix, input logic [DW-1:0] fix);
        cyc_t          c;
        logic [DW-1:0] rdata;
        logic [3:0]    setb, clrb;
        logic [5:0]    sel;
        bit            busy_pre, idle_pre;
        int            ph, k;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_held[i]   = '0;
                m_shadow[i] = '0;
            end
            m_flag = '0;
            m_mask = 4'hF;
            m_data = '0;
            m_n    = 0;
            m_s    = -1;
            c      = '0;
            stq.push_back(c);
            return;
        end
        m_n++;
        busy_pre = (m_s >= 0) && (m_n - 1 >= m_s) && (m_n - 1 <= m_s + 3);
        idle_pre = (m_s < 0) || (m_n - 1 >= m_s + 5);
        setb  = '0;
        clrb  = '0;
        rdata = '0;
        sel   = a[7:2];
        if (rd) begin
            if (sel >= 6'd48 && sel <= 6'd51) begin
                k       = int'(sel) - 48;
                rdata   = m_held[k];
                clrb[k] = 1'b1;
            end else if (sel == 6'd52) begin
                rdata = DW'({busy_pre, m_flag});
            end
`ifdef IO_INPUT_IRQ_EN
            else if (sel == 6'd53) begin
                m_mask = a[11:8];
            end
`endif
            m_data = rdata;
            rdq.push_back(use_fix ? fix : rdata);
        end
        if (m_s >= 0) begin
            ph = m_n - m_s;
            if (ph == 5) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_shadow[i] != m_held[i]) begin
                        m_held[i] = m_shadow[i];
                        setb[i]   = 1'b1;
                    end
                end
            end else if (ph >= 1 && ph <= 4) begin
                m_shadow[ph - 1] = p[ph - 1];
            end
        end
        m_flag = setb | (m_flag & ~clrb);
        if (idle_pre && (m_n % int'(SD)) == 0) m_s = m_n;
        c.valid = rd;
        c.busy  = (m_s >= 0) && (m_n >= m_s) && (m_n <= m_s + 3);
`ifdef IO_INPUT_IRQ_EN
        c.irq   = |(m_flag & m_mask);
`else
        c.irq   = 1'b0;
`endif
        c.data  = m_data;
        stq.push_back(c);
    endfunction

    task automatic step(input logic r, input logic rd, input logic [31:0] a,
                        input logic use_fix = 1'b0, input logic [DW-1:0] fix = '0);
        rst        = r;
        bus.rd_en  = rd;
        bus.addr   = a;
        @(posedge clk);
        model_edge(r, rd, a, use_fix, fix);
        #2;
    endtask

    // Monitor: one expected record per cycle, plus read data whenever the DUT raises rd_valid.
    initial begin
        cyc_t c;
        forever begin
            @(negedge clk);
            if (stq.size() != 0) begin
                c = stq.pop_front();
                check("rd_valid", DW'(bus.rd_valid), DW'(c.valid));
                check("scan_busy", DW'(scan_busy), DW'(c.busy));
                check("irq", DW'(irq), DW'(c.irq));
                if (bus.rd_valid) begin
                    if (rdq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rd_unexpected at %0t: got data %h expected no read", $time, bus.in_data);
                    end else begin
                        check("rd_data", bus.in_data, rdq.pop_front());
                    end
                end else begin
                    check("hold_data", bus.in_data, c.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r, rd;
        logic [31:0] a;
        logic [1:0]  j;
        rst       = 1'b1;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        for (int i = 0; i < 4; i++) p[i] = '0;
        p[2] = 32'hA5A5_0001;

        // Edge numbers below count non-reset edges since release (SD = 4).
        repeat (3) step(1'b1, 1'b0, 32'h0);
        repeat (10) step(1'b0, 1'b0, 32'h0);                 // scan 4..8, commit 9
        step(1'b0, 1'b1, 32'hD0, 1'b1, 32'h4);               // 11: STATUS
        step(1'b0, 1'b1, 32'hC8, 1'b1, 32'hA5A5_0001);       // 12: port2, scan starts
        repeat (6) step(1'b0, 1'b0, 32'h0);                  // 13..18
        step(1'b0, 1'b1, 32'hD0, 1'b1, 32'h0);               // 19: flags cleared
        repeat (24) step(1'b0, 1'b0, 32'h0);                 // 20..43: three quiet scans
        step(1'b0, 1'b1, 32'hD0, 1'b1, 32'h0);               // 44: scan starts
        p[1] = 32'h1111_0000;
        repeat (7) step(1'b0, 1'b0, 32'h0);                  // 45..51, commit 49
        step(1'b0, 1'b1, 32'hC4, 1'b1, 32'h1111_0000);       // 52: scan starts
        p[1] = 32'h2222_0000;
        repeat (4) step(1'b0, 1'b0, 32'h0);                  // 53..56
        step(1'b0, 1'b1, 32'hC4, 1'b1, 32'h1111_0000);       // 57: read in COMMIT
        step(1'b0, 1'b1, 32'hD0, 1'b1, 32'h2);               // 58: flag1 survived
        step(1'b0, 1'b1, 32'hC4, 1'b1, 32'h2222_0000);       // 59
        step(1'b0, 1'b0, 32'h0);                             // 60: scan starts
        for (int i = 0; i < 4; i++) p[i] = 32'hC0DE_0000 | 32'(i + 1);
        repeat (2) step(1'b0, 1'b0, 32'h0);                  // 61,62: idx 0,1 sampled
        step(1'b1, 1'b0, 32'h0);                             // reset while idx = 2
        step(1'b0, 1'b1, 32'hD0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'hC0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'hC4, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'hC8, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'hCC, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'hD4, 1'b1, 32'h0);               // mask slot or unmapped: zero
        step(1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0);        // unmapped

`ifdef IO_INPUT_IRQ_EN
        repeat (12) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hC0);
        step(1'b0, 1'b1, 32'hC4);
        step(1'b0, 1'b1, 32'hC8);
        step(1'b0, 1'b1, 32'hCC);
        step(1'b0, 1'b1, 32'h0000_01D4, 1'b1, 32'h0);        // mask = 4'b0001
        p[3] = 32'h3333_3333;
        repeat (12) step(1'b0, 1'b0, 32'h0);
        p[0] = 32'h0000_0F0F;
        repeat (12) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hC0, 1'b1, 32'h0000_0F0F);
        repeat (4) step(1'b0, 1'b0, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) begin
                j    = 2'($urandom_range(3));
                p[j] = $urandom;
            end
            rd = ($urandom_range(2) == 0);
            a  = $urandom;
            if ($urandom_range(7) < 6) a[7:2] = 6'(48 + $urandom_range(5));
            r  = ($urandom_range(499) == 0);
            step(r, rd, a);
        end

        step(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        n_checks++;
        if (stq.size() != 0 || rdq.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", stq.size(), rdq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 Parameter DATA_W, 32: width of each input port and of read data.
REQ-002 Parameter SAMPLE_DIV, 4: io_clk cycles between scan starts, legal range 2..255.
REQ-003 io_clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge io_clk.
REQ-005 addr  in  32  CPU byte address; addr[7:2] selects the register.
REQ-006 rd_en  in  1  CPU read strobe, one cycle per access.
REQ-007 in_port0..in_port3  in  DATA_W each  raw external input ports.
REQ-008 in_data  out  DATA_W  registered read data.
REQ-009 rd_valid  out  1  pulses high the cycle in_data is valid.
REQ-010 scan_busy  out  1  high while the scan FSM is in SCAN.
REQ-011 irq  out  1  level interrupt, present only per REQ-031.

Function
REQ-012 Address map (addr[7:2]): 110000 port0, 110001 port1, 110010 port2, 110011 port3, 110100 STATUS.
REQ-013 STATUS read value: bits[3:0] = chg_flag[3:0], bit[4] = scan_busy, bits[DATA_W-1:5] = 0.
REQ-014 Tick counter counts 0..SAMPLE_DIV-1, then wraps to 0; tick asserts on the wrap cycle.
REQ-015 FSM states: IDLE, SCAN, COMMIT.
REQ-016 IDLE -> SCAN on tick; otherwise stay in IDLE.
REQ-017 SCAN holds a 2-bit index idx starting at 0; each cycle: shadow[idx] <= in_port[idx], idx++.
REQ-018 SCAN -> COMMIT in the cycle after idx=3 is sampled; a full scan takes exactly 4 SCAN cycles.
REQ-019 COMMIT (1 cycle): for each port, if shadow != held data then held <= shadow and chg_flag <= 1. Always -> IDLE.
REQ-020 Ticks occurring while not in IDLE are dropped, not queued.
REQ-021 A read with rd_en=1 at cycle N: in_data and rd_valid are updated at edge N+1 (1-cycle latency).
REQ-022 A read of port k returns held[k], never shadow[k], and clears chg_flag[k] at the same edge.
REQ-023 A read of STATUS returns flags but does not clear them.
REQ-024 If COMMIT sets chg_flag[k] in the same cycle a read of port k clears it, set wins: flag = 1 and old held data is returned.
REQ-025 An unmapped address with rd_en=1 returns 0, still pulses rd_valid, and changes no state.
REQ-026 With rd_en=0, rd_valid = 0 and in_data holds its last value.

Reset
REQ-027 On reset: FSM = IDLE, idx = 0, tick counter = 0, shadow = 0, held = 0, chg_flag = 0.
REQ-028 On reset: in_data = 0, rd_valid = 0, scan_busy = 0, irq = 0.
REQ-029 Reset asserted mid-SCAN or mid-COMMIT aborts the scan; no held or flag update occurs from that scan.
REQ-030 The first tick after reset release occurs SAMPLE_DIV cycles after the first non-reset edge.

Configuration
REQ-031 Macro IO_INPUT_IRQ_EN defined: irq is registered, irq = |(chg_flag & irq_mask), where irq_mask[3:0] is reset to 4'hF.
REQ-032 With IO_INPUT_IRQ_EN defined, irq_mask is written from addr bits via a read of STATUS+4 (addr[7:2] = 110101, mask = addr[11:8]); that read returns 0.
REQ-033 Macro IO_INPUT_IRQ_EN undefined: irq is tied 0, irq_mask and address 110101 do not exist, and 110101 reads as unmapped.

Structure
REQ-034 A shared package io_pkg holds the address-select constants (ADDR_PORT0..3, ADDR_STATUS, ADDR_IRQMASK) and the FSM state enum.
REQ-035 One sub-module, io_scan_fsm, contains the tick counter, FSM, and idx; the top level holds the registers, read mux, and flags.

Verification
REQ-036 Reset, then in_port2=32'hA5A5_0001 held, SAMPLE_DIV=4 -> chg_flag[2]=1 and held[2]=32'hA5A5_0001 after the first COMMIT; STATUS reads 32'h4.
REQ-037 Read port2 (addr 0xC8) -> the next cycle gives in_data=32'hA5A5_0001 and rd_valid=1; a subsequent STATUS read returns 32'h0.
REQ-038 Unchanged inputs over 3 scans -> chg_flag remains 0 and irq remains 0.
REQ-039 Port1 read issued in the COMMIT cycle of a port1 change -> old value is returned and chg_flag[1] remains 1.
REQ-040 Reset asserted during SCAN idx=2 with new values on all ports -> all held values are 0 and all flags are 0 after release until the next full scan.
REQ-041 IO_INPUT_IRQ_EN defined, mask set to 4'b0001, port3 change -> irq stays 0; port0 change -> irq=1 the cycle after COMMIT; read port0 -> irq=0.
